// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected layer, one shared MAC.
//
// For each output neuron j, the block walks i = 0..N_IN-1 and accumulates
// sat(x[i]*w[i*N_OUT+j] >>> FRAC). It then adds the bias b[j], saturates
// the sum to DW bits, optionally applies ReLU, and presents the result on a
// valid/ready output port.
//
// Ports:
//   clk      rising-edge clock
//   RST      synchronous, active-high reset
//   start    begin one layer evaluation (sampled only in IDLE)
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle pulse after the last output is accepted
//   x_addr   activation read address (i); x_data is valid one cycle later
//   x_data   activation
//   w_addr   weight read address (i*N_OUT+j); w_data is valid one cycle later
//   w_data   weight
//   b_addr   bias address (j); b_data is combinational from b_addr
//   b_data   bias
//   y_valid  output word valid (only in OUT)
//   y_ready  downstream accept
//   y_data   output value
//   y_idx    neuron index of y_data
module fc_layer_seq #(
    parameter int N_IN    = 84,
    parameter int N_OUT   = 10,
    parameter int DW      = 16,
    parameter int FRAC    = 12,
    parameter int ACC_W   = 32,
    parameter int RELU_EN = 0
) (
    input  logic                            clk,
    input  logic                            RST,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(N_IN)-1:0]         x_addr,
    input  logic [DW-1:0]                   x_data,
    output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
    input  logic [DW-1:0]                   w_data,
    output logic [$clog2(N_OUT)-1:0]        b_addr,
    input  logic [DW-1:0]                   b_data,
    output logic                            y_valid,
    input  logic                            y_ready,
    output logic [DW-1:0]                   y_data,
    output logic [$clog2(N_OUT)-1:0]        y_idx
);

    localparam int XW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN*N_OUT);
    localparam int JW = $clog2(N_OUT);

    localparam logic [XW-1:0] I_LAST = XW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
    localparam logic [WW-1:0] W_STEP = WW'(N_OUT);

    // Saturation limits expressed at the width of the value being clamped.
    localparam logic signed [2*DW-1:0] P_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] P_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W:0]  S_MAX = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0]  S_MIN = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0]   D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   D_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        BIAS,
        OUT
    } state_t;

    state_t state, state_next;

    logic        [XW-1:0]    i;
    logic        [JW-1:0]    j;
    logic        [JW-1:0]    j_inc;
    logic        [WW-1:0]    w_ptr;
    logic signed [ACC_W-1:0] acc;

    logic signed [2*DW-1:0]  prod_full;
    logic signed [2*DW-1:0]  prod_shift;
    logic signed [DW-1:0]    prod_sat;
    logic signed [ACC_W-1:0] prod_ext;

    logic signed [ACC_W:0]   bias_sum;
    logic signed [DW-1:0]    bias_sat;
    logic signed [DW-1:0]    y_next;

    assign x_addr  = i;
    assign w_addr  = w_ptr;
    assign b_addr  = j;
    assign y_valid = (state == OUT);
    assign j_inc   = j + JW'(1);

    // Product path: full-width multiply, floor shift, clamp to DW.
    always_comb begin
        prod_full  = $signed(x_data) * $signed(w_data);
        prod_shift = prod_full >>> FRAC;
        if (prod_shift > P_MAX) begin
            prod_sat = D_MAX;
        end else if (prod_shift < P_MIN) begin
            prod_sat = D_MIN;
        end else begin
            prod_sat = prod_shift[DW-1:0];
        end
        prod_ext = {{(ACC_W-DW){prod_sat[DW-1]}}, prod_sat};
    end

    // Bias path: one extra bit so the bias add itself can never wrap.
    always_comb begin
        bias_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-DW){b_data[DW-1]}}, b_data};
        if (bias_sum > S_MAX) begin
            bias_sat = D_MAX;
        end else if (bias_sum < S_MIN) begin
            bias_sat = D_MIN;
        end else begin
            bias_sat = bias_sum[DW-1:0];
        end
        if ((RELU_EN != 0) && bias_sat[DW-1]) begin
            y_next = '0;
        end else begin
            y_next = bias_sat;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (i == I_LAST) state_next = DRAIN;
            DRAIN:   state_next = BIAS;
            BIAS:    state_next = OUT;
            OUT:     if (y_ready) state_next = (j == J_LAST) ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath. Read data lags the address by one cycle, so the product of
    // MAC cycle i is accumulated in the following cycle: MAC with i>0
    // accumulates product i-1, and DRAIN picks up the final product.
    always_ff @(posedge clk) begin
        if (RST) begin
            i      <= '0;
            j      <= '0;
            w_ptr  <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            y_data <= '0;
            y_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= '0;
                        j     <= '0;
                        w_ptr <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    if (i != '0) begin
                        acc <= acc + prod_ext;
                    end
                    // Addresses stop on the last element and hold there.
                    if (i != I_LAST) begin
                        i     <= i + XW'(1);
                        w_ptr <= w_ptr + W_STEP;
                    end
                end
                DRAIN: begin
                    acc <= acc + prod_ext;
                end
                BIAS: begin
                    y_data <= y_next;
                    y_idx  <= j;
                end
                OUT: begin
                    if (y_ready) begin
                        if (j == J_LAST) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            j     <= j_inc;
                            i     <= '0;
                            w_ptr <= WW'(j_inc);
                            acc   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq with N_IN=4, N_OUT=2, DW=16, FRAC=12.
// Two instances (ReLU off / on) share stimulus and memories are modelled
// per instance with one-cycle read latency on x/w and combinational bias.
module tb_fc_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int DW    = 16;
    localparam int FRAC  = 12;

    logic clk;
    logic RST;
    logic start;
    logic y_ready;

    logic        busy0, done0, y_valid0;
    logic [1:0]  x_addr0;
    logic [2:0]  w_addr0;
    logic        b_addr0;
    logic [15:0] x_data0, w_data0, b_data0, y_data0;
    logic        y_idx0;

    logic        busy1, done1, y_valid1;
    logic [1:0]  x_addr1;
    logic [2:0]  w_addr1;
    logic        b_addr1;
    logic [15:0] x_data1, w_data1, b_data1, y_data1;
    logic        y_idx1;

    logic [15:0] x_mem [N_IN];
    logic [15:0] w_mem [N_IN*N_OUT];
    logic [15:0] b_mem [N_OUT];
    logic [15:0] exp0  [N_OUT];
    logic [15:0] exp1  [N_OUT];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    fc_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(32), .RELU_EN(0)
    ) u0 (
        .clk(clk), .RST(RST), .start(start), .busy(busy0), .done(done0),
        .x_addr(x_addr0), .x_data(x_data0), .w_addr(w_addr0), .w_data(w_data0),
        .b_addr(b_addr0), .b_data(b_data0), .y_valid(y_valid0), .y_ready(y_ready),
        .y_data(y_data0), .y_idx(y_idx0)
    );

    fc_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(32), .RELU_EN(1)
    ) u1 (
        .clk(clk), .RST(RST), .start(start), .busy(busy1), .done(done1),
        .x_addr(x_addr1), .x_data(x_data1), .w_addr(w_addr1), .w_data(w_data1),
        .b_addr(b_addr1), .b_data(b_data1), .y_valid(y_valid1), .y_ready(y_ready),
        .y_data(y_data1), .y_idx(y_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_data0 <= x_mem[x_addr0];
        w_data0 <= w_mem[w_addr0];
        x_data1 <= x_mem[x_addr1];
        w_data1 <= w_mem[w_addr1];
        if (done0) done_cnt <= done_cnt + 1;
    end

    always_comb begin
        b_data0 = b_mem[b_addr0];
        b_data1 = b_mem[b_addr1];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N_IN-1:0][15:0]       x;
        logic [N_IN*N_OUT-1:0][15:0] w;
        logic [N_OUT-1:0][15:0]      b;
        int                          stall;
        bit                          mid_start;
        logic [N_OUT-1:0][15:0]      e0;
        logic [N_OUT-1:0][15:0]      e1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: y[j] = relu?(sat(sum_i sat(floor(x*w / 2^FRAC)) + b[j]))
    function automatic logic [15:0] model_y(input int j, input bit relu);
        longint acc;
        longint p;
        logic [15:0] r;
        acc = 0;
        for (int i = 0; i < N_IN; i++) begin
            p = longint'($signed(x_mem[i])) * longint'($signed(w_mem[i*N_OUT+j]));
            p = p >>> FRAC;
            acc += clamp16(p);
        end
        acc = clamp16(acc + longint'($signed(b_mem[j])));
        if (relu && acc < 0) acc = 0;
        r = acc[15:0];
        return r;
    endfunction

    task automatic load_vec(input int v);
        for (int i = 0; i < N_IN; i++) x_mem[i] = vecs[v].x[i];
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = vecs[v].w[k];
        for (int j = 0; j < N_OUT; j++) begin
            b_mem[j] = vecs[v].b[j];
            exp0[j]  = vecs[v].e0[j];
            exp1[j]  = vecs[v].e1[j];
        end
    endtask

    // One full evaluation against exp0/exp1, with optional output stall and
    // an ignored start pulse in the middle of MAC.
    task automatic run_layer(input int stall, input bit mid_start, input string tag);
        int n;
        int dc;
        dc = done_cnt;
        y_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s x_addr first MAC j%0d", tag, j), 32'(x_addr0), 0);
            check($sformatf("%s w_addr first MAC j%0d", tag, j), 32'(w_addr0), j);
            while (!y_valid0 && n < 200) begin
                @(negedge clk);
                n++;
                start = (mid_start && j == 0 && n == 2);
            end
            start = 1'b0;
            check($sformatf("%s latency j%0d", tag, j), n, N_IN + 3);
            check($sformatf("%s y_data0 j%0d", tag, j), 32'(y_data0), 32'(exp0[j]));
            check($sformatf("%s y_data1 j%0d", tag, j), 32'(y_data1), 32'(exp1[j]));
            check($sformatf("%s y_idx0 j%0d", tag, j), 32'(y_idx0), j);
            check($sformatf("%s y_valid1 j%0d", tag, j), 32'(y_valid1), 1);
            check($sformatf("%s busy j%0d", tag, j), 32'(busy0), 1);
            if (stall > 0) begin
                y_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check($sformatf("%s stall valid j%0d c%0d", tag, j, s), 32'(y_valid0), 1);
                    check($sformatf("%s stall data j%0d c%0d", tag, j, s), 32'(y_data0), 32'(exp0[j]));
                    check($sformatf("%s stall idx j%0d c%0d", tag, j, s), 32'(y_idx0), j);
                end
                y_ready = 1'b1;
            end
            @(negedge clk);
            n = 1;
        end
        check({tag, " done0"}, 32'(done0), 1);
        check({tag, " done1"}, 32'(done1), 1);
        check({tag, " busy after"}, 32'(busy0), 0);
        check({tag, " y_valid after"}, 32'(y_valid0), 0);
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done0), 0);
        check({tag, " done count"}, done_cnt - dc, 1);
    endtask

    initial begin
        int n;
        int dc;
        bit seen;

        // nominal
        vecs[0].x = {N_IN{16'h1000}};
        vecs[0].w = {(N_IN*N_OUT){16'h0800}};
        vecs[0].b = {16'hFC00, 16'h0400};
        vecs[0].stall = 0; vecs[0].mid_start = 0;
        vecs[0].e0 = {16'h1C00, 16'h2400};
        vecs[0].e1 = {16'h1C00, 16'h2400};
        // nominal with backpressure
        vecs[1] = vecs[0];
        vecs[1].stall = 5;
        // nominal with start pulsed during MAC
        vecs[2] = vecs[0];
        vecs[2].mid_start = 1;
        // positive saturation
        vecs[3].x = {N_IN{16'h7FFF}};
        vecs[3].w = {(N_IN*N_OUT){16'h7FFF}};
        vecs[3].b = {16'h7FFF, 16'h7FFF};
        vecs[3].stall = 0; vecs[3].mid_start = 0;
        vecs[3].e0 = {16'h7FFF, 16'h7FFF};
        vecs[3].e1 = {16'h7FFF, 16'h7FFF};
        // negative saturation
        vecs[4].x = {N_IN{16'h7FFF}};
        vecs[4].w = {(N_IN*N_OUT){16'h8000}};
        vecs[4].b = {16'h8000, 16'h8000};
        vecs[4].stall = 0; vecs[4].mid_start = 0;
        vecs[4].e0 = {16'h8000, 16'h8000};
        vecs[4].e1 = {16'h0000, 16'h0000};
        // ReLU: 4 * (1.0 * -1.0) = -4.0
        vecs[5].x = {N_IN{16'h1000}};
        vecs[5].w = {(N_IN*N_OUT){16'hF000}};
        vecs[5].b = {16'h0000, 16'h0000};
        vecs[5].stall = 0; vecs[5].mid_start = 0;
        vecs[5].e0 = {16'hC000, 16'hC000};
        vecs[5].e1 = {16'h0000, 16'h0000};
        // shift floors toward -inf: each product is -1 LSB
        vecs[6].x = {N_IN{16'h0001}};
        vecs[6].w = {(N_IN*N_OUT){16'hFFFF}};
        vecs[6].b = {16'h0000, 16'h0000};
        vecs[6].stall = 0; vecs[6].mid_start = 0;
        vecs[6].e0 = {16'hFFFC, 16'hFFFC};
        vecs[6].e1 = {16'h0000, 16'h0000};
        // addressing: neuron 0 picks x[0], neuron 1 picks x[3] (+bias 0x10)
        vecs[7].x = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        vecs[7].w = {16'h1000, 16'h0000, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, 16'h0000, 16'h1000};
        vecs[7].b = {16'h0010, 16'h0000};
        vecs[7].stall = 0; vecs[7].mid_start = 0;
        vecs[7].e0 = {16'h0410, 16'h0100};
        vecs[7].e1 = {16'h0410, 16'h0100};

        for (int i = 0; i < N_IN; i++) x_mem[i] = '0;
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = '0;
        for (int j = 0; j < N_OUT; j++) b_mem[j] = '0;

        // Reset state
        RST = 1'b1;
        start = 1'b0;
        y_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy0), 0);
        check("reset done", 32'(done0), 0);
        check("reset y_valid", 32'(y_valid0), 0);
        check("reset y_data", 32'(y_data0), 0);
        check("reset y_idx", 32'(y_idx0), 0);
        check("reset x_addr", 32'(x_addr0), 0);
        check("reset b_addr", 32'(b_addr0), 0);
        RST = 1'b0;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            load_vec(v);
            run_layer(vecs[v].stall, vecs[v].mid_start, $sformatf("vec%0d", v));
        end

        // Reset during MAC of neuron 1 at i=2, with start asserted alongside
        load_vec(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!y_valid0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort first valid", n, N_IN + 3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort at i=2 x_addr", 32'(x_addr0), 2);
        check("abort at j=1 b_addr", 32'(b_addr0), 1);
        RST = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy0), 0);
        check("abort done", 32'(done0), 0);
        check("abort y_valid", 32'(y_valid0), 0);
        check("abort y_data", 32'(y_data0), 0);
        check("abort y_idx", 32'(y_idx0), 0);
        check("abort x_addr", 32'(x_addr0), 0);
        RST = 1'b0;
        start = 1'b0;
        dc = done_cnt;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (y_valid0 || y_valid1 || done0 || busy0) seen = 1'b1;
        end
        check("abort quiet", 32'(seen), 0);
        check("abort no done", done_cnt - dc, 0);
        load_vec(5);
        run_layer(0, 0, "after abort");

        // Randomized against the reference model
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (it % 2 == 1) x_mem[i] = 16'($urandom());
                else x_mem[i] = 16'($urandom_range(0, 16'h2000)) - 16'h1000;
            end
            for (int k = 0; k < N_IN*N_OUT; k++) begin
                if (it % 3 == 2) w_mem[k] = 16'($urandom());
                else w_mem[k] = 16'($urandom_range(0, 16'h4000)) - 16'h2000;
            end
            for (int j = 0; j < N_OUT; j++) begin
                b_mem[j] = 16'($urandom());
                exp0[j] = model_y(j, 1'b0);
                exp1[j] = model_y(j, 1'b1);
            end
            run_layer((it % 3 == 0) ? int'($urandom_range(1, 4)) : 0, (it % 4 == 1),
                      $sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

Interface
REQ-001 Parameter N_IN, default 84: number of input activations.
REQ-002 Parameter N_OUT, default 10: number of output neurons.
REQ-003 Parameter DW, default 16: signed fixed-point data width for X, W, B and Y.
REQ-004 Parameter FRAC, default 12: fractional bits, so the default format is Q4.12.
REQ-005 Parameter ACC_W, default 32: signed accumulator width; ACC_W SHALL be at least DW+$clog2(N_IN)+1.
REQ-006 Parameter RELU_EN, default 0: 1 enables ReLU on outputs.
REQ-007 Ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  begin one layer evaluation; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last output is accepted.
- x_addr  out  $clog2(N_IN)  activation read address.
- x_data  in  DW  activation; valid one cycle after x_addr.
- w_addr  out  $clog2(N_IN*N_OUT)  weight read address, equal to i*N_OUT+j.
- w_data  in  DW  weight; valid one cycle after w_addr.
- b_addr  out  $clog2(N_OUT)  bias address, equal to j.
- b_data  in  DW  bias; stable while b_addr is constant.
- y_valid  out  1  output word valid.
- y_ready  in  1  downstream accept.
- y_data  out  DW  output value.
- y_idx  out  $clog2(N_OUT)  neuron index j of y_data.

Function
REQ-008 The FSM SHALL have the states IDLE, MAC, DRAIN, BIAS and OUT.
REQ-009 IDLE with start=1 SHALL go to MAC with j=0, i=0 and acc=0; start while not in IDLE SHALL be ignored.
REQ-010 MAC SHALL run N_IN cycles, driving x_addr=i and w_addr=i*N_OUT+j and incrementing i each cycle.
REQ-011 Each cycle after an address is issued, the block SHALL accumulate acc += P(x_data,w_data); MAC SHALL then go to DRAIN for the last product.
REQ-012 P SHALL be computed as: full 2*DW signed product, arithmetic shift right by FRAC (truncation toward -inf), then saturation to the DW signed range [-2^(DW-1), 2^(DW-1)-1].
REQ-013 BIAS SHALL compute s = acc + sign-extended b_data, saturate s to DW signed, apply max(s,0) if RELU_EN=1, register the result into y_data, set y_idx=j, and go to OUT.
REQ-014 OUT SHALL hold y_valid=1 with y_data and y_idx stable until y_ready=1.
REQ-015 On acceptance in OUT with j<N_OUT-1, the block SHALL set j++, i=0, acc=0 and go to MAC.
REQ-016 On acceptance in OUT with j=N_OUT-1, the block SHALL pulse done for one cycle, drop busy and go to IDLE.
REQ-017 Latency: with start sampled at edge k and y_ready held at 1, y_valid for j=0 SHALL first be high in cycle k+N_IN+3.
REQ-018 Per-neuron period without backpressure SHALL be N_IN+3 cycles.
REQ-019 The accumulator SHALL NOT wrap; ACC_W sizing per REQ-005 makes overflow impossible.
REQ-020 y_valid SHALL be 0 in every state except OUT.
REQ-021 Address outputs SHALL hold their last value outside MAC.

Reset
REQ-022 With RST=1 at a rising edge, the state SHALL become IDLE, and busy, done, y_valid, y_data, y_idx, i, j and acc SHALL all be 0.
REQ-023 RST SHALL take priority over start and y_ready in the same cycle.
REQ-024 RST mid-operation SHALL abort the evaluation with no further y_valid or done.
REQ-025 After reset, the next start SHALL begin from j=0.

Verification (N_IN=4, N_OUT=2, DW=16, FRAC=12)
REQ-026 Nominal: all X=0x1000, all W=0x0800, B={0x0400,0xFC00}, y_ready=1 -> y_data 0x2400 (idx 0) then 0x1C00 (idx 1); first y_valid at k+7; done one cycle after the second accept.
REQ-027 Saturation: X=W=0x7FFF, B=0x7FFF -> each product saturates to 0x7FFF and y_data=0x7FFF; X=0x7FFF, W=0x8000, B=0x8000 -> y_data=0x8000.
REQ-028 ReLU: RELU_EN=1, X=0x1000, W=0xF000 (-1.0), B=0 -> y_data=0x0000; the same case with RELU_EN=0 -> y_data=0xC000.
REQ-029 Backpressure: y_ready=0 for 5 cycles in OUT -> y_valid, y_data and y_idx stay stable; MAC for idx 1 starts the cycle after the accept.
REQ-030 Reset mid-MAC: RST pulsed at i=2 of j=1 -> all outputs 0 next cycle, no done; a new start yields the correct idx 0 result.
REQ-031 Start while busy: start pulsed during MAC -> no effect on addresses, results or done count (exactly one done per accepted start).
